fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch sequencer that owns the PC register's `pc_sel` control and the instruction-memory request handshake. It issues one outstanding fetch at a time, presents fetched instructions to the IF/ID stage with a valid/ready handshake, and handles branch redirects and ID stalls. When the PC reaches the halt address it stops fetching. It sits between the PC register, instruction memory and the IF/ID pipeline register.

## Interface
Parameters:
- `HALT_ADDR`, default 32'd2048. When the PC equals this byte address, fetching stops.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `pc_cur`  in  32  current PC register value
- `pc_sel`  out  2  PC next-value select:
  - 00 = +4
  - 01 = redirect (alu_out)
  - 10 = hold
  - 11 is never driven
- `branch_taken`  in  1  single-cycle redirect pulse from EX
- `stall`  in  1  hazard-unit stall; blocks hand-off to ID
- `im_req`  out  1  instruction-memory request
- `im_addr`  out  14  word address, `pc[15:2]` latched at issue
- `im_ack`  in  1  memory response strobe, carries `im_rdata`
- `im_rdata`  in  32  fetched instruction
- `inst_valid`  out  1  instruction available to ID
- `inst`  out  32  instruction to ID
- `inst_pc`  out  32  byte PC of `inst`
- `id_ready`  in  1  ID can accept
- `halted`  out  1  fetch stopped at `HALT_ADDR`

## Operation
- **States:** IDLE, ISSUE, WAIT, OUT, HALT.
- **Fire:** `fire = inst_valid & id_ready & ~stall & ~branch_taken`.
- **`pc_sel` default:** 10 (hold) in every state unless a rule below says otherwise.
- **IDLE** → ISSUE, unconditionally.
- **ISSUE:**
  - If `pc_cur == HALT_ADDR` → HALT.
  - Otherwise latch `im_addr = pc_cur[15:2]` and `req_pc = pc_cur`, then → WAIT.
- **WAIT:**
  - `im_req = 1`. `im_addr` stays stable until `im_ack`; a request is never withdrawn.
  - On `im_ack` with squash clear: capture `inst = im_rdata`, `inst_pc = req_pc`, drive `pc_sel = 00` that cycle, → OUT.
  - On `im_ack` with squash set: discard data, clear squash, → ISSUE.
- **OUT:**
  - `inst_valid = 1`. `inst` and `inst_pc` stay stable while not fired.
  - On fire → ISSUE.
- **HALT:**
  - `halted = 1`, `pc_sel = 10`. Terminal until reset.
  - `branch_taken` is ignored.
- **Redirect (`branch_taken`), highest priority outside HALT.** `pc_sel = 01` that cycle, plus:
  - ISSUE: stay in ISSUE; the halt check is re-evaluated next cycle against the new PC.
  - WAIT without `im_ack`: set squash, stay in WAIT.
  - WAIT with `im_ack`: discard the data, → ISSUE. The redirect overrides the 00.
  - OUT: drop `inst_valid` (flush), → ISSUE. No fire occurs even if `id_ready` is high.
- **`stall`:** affects only the OUT hand-off. Memory requests continue during WAIT.

## Timing
- **Reset values:**
  - state IDLE
  - `pc_sel = 10`, `im_req = 0`, `im_addr = 0`
  - `inst_valid = 0`, `inst = 0`, `inst_pc = 0`
  - `halted = 0`, squash 0, `req_pc = 0`
- **Reset mid-operation:** abandons any request immediately. A late `im_ack` after reset is ignored, because the state is not WAIT.
- **Startup:** first `im_req` rises 2 cycles after reset deasserts (IDLE, then ISSUE).
- **Response latency:** `im_ack` at cycle N → `inst_valid` at N+1.
- **Throughput:** best case one instruction per 3 cycles (ISSUE, WAIT with same-cycle ack, OUT with fire).
- **Outputs:** `pc_sel` is combinational from state and inputs. All other outputs are registered.

## Configuration
- **`FETCH_CTRL_PERF_EN` defined:** adds output ports `perf_fetch_cnt` [31:0] and `perf_squash_cnt` [31:0].
  - `perf_fetch_cnt` increments on each fire.
  - `perf_squash_cnt` increments on each discarded response and each OUT flush.
  - Both reset to 0 and wrap at 2^32.
- **Not defined:** ports and counters are absent. Behaviour is otherwise identical.

## Structure
- **Package `fetch_pkg`:**
  - `pc_sel_t` enum: `PC_INC` = 2'b00, `PC_REDIRECT` = 2'b01, `PC_HOLD` = 2'b10.
  - `fetch_state_t` enum (IDLE, ISSUE, WAIT, OUT, HALT).
  - `HALT_ADDR_DEF` = 32'd2048.
- **Sub-module `fetch_perf_cnt`:** the two counters. Instantiated only under `FETCH_CTRL_PERF_EN`.

## Test plan
- **Reset, PC=0, ack 2 cycles after `im_req`:**
  - `im_addr` = 0, `pc_sel` = 00 for exactly the ack cycle.
  - Next cycle: `inst_valid` = 1, `inst_pc` = 0, `inst` = `im_rdata` (0x00000013).
- **`branch_taken` 1 cycle into WAIT, PC redirected to 0x40:**
  - First response discarded; `inst_valid` stays 0.
  - Next `im_addr` = 0x10; `inst_pc` = 0x40.
- **`branch_taken` in the same cycle as `im_ack`:**
  - `pc_sel` = 01, data discarded, no `inst_valid` pulse.
- **OUT with `stall` = 1 for 3 cycles, `id_ready` = 1:**
  - `inst`/`inst_pc` stable and `pc_sel` = 10 throughout.
  - Fire on the first cycle `stall` = 0; then ISSUE.
- **`pc_cur` = 2048 in ISSUE:**
  - `im_req` never rises, `halted` = 1, `pc_sel` = 10.
  - A subsequent `branch_taken` pulse leaves `halted` = 1.
- **`rst` asserted during WAIT:**
  - `im_req` = 0 immediately; a late `im_ack` is ignored.
  - `im_req` rises again 2 cycles after `rst` deasserts, at `im_addr` = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: PC select encoding,
// fetch FSM states and the default halt address.
package fetch_pkg;

    typedef enum logic [1:0] {
        PC_INC      = 2'b00,
        PC_REDIRECT = 2'b01,
        PC_HOLD     = 2'b10
    } pc_sel_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT,
        HALT
    } fetch_state_t;

    localparam logic [31:0] HALT_ADDR_DEF = 32'd2048;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: completed hand-offs to ID and squashed work
// (discarded memory responses plus flushed OUT instructions). Both wrap.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fire,
    input  logic        squash_evt,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_squash_cnt
);

    logic [31:0] fetch_cnt_d, fetch_cnt_q;
    logic [31:0] squash_cnt_d, squash_cnt_q;

    // Next-count logic; natural 32-bit overflow gives the wrap.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (fire) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (squash_evt) begin
            squash_cnt_d = squash_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_squash_cnt = squash_cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. Keeps a single fetch outstanding, hands the
// instruction to IF/ID with a valid/ready handshake, squashes work on branch
// redirects and stops for good once the PC reaches HALT_ADDR.
// Optional build macro FETCH_CTRL_PERF_EN adds the perf counter outputs.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic [1:0]  pc_sel,
    input  logic        branch_taken,
    input  logic        stall,
    output logic        im_req,
    output logic [13:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        id_ready,
    output logic        halted
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_squash_cnt
`endif
);

    fetch_state_t state_d, state_q;
    logic         im_req_d, im_req_q;
    logic [13:0]  im_addr_d, im_addr_q;
    logic         inst_valid_d, inst_valid_q;
    logic [31:0]  inst_d, inst_q;
    logic [31:0]  inst_pc_d, inst_pc_q;
    logic         halted_d, halted_q;
    logic         squash_d, squash_q;
    logic [31:0]  req_pc_d, req_pc_q;
    pc_sel_t      pc_sel_c;
    logic         fire;

    // A redirect in the same cycle cancels the hand-off, so ID never sees a
    // wrong-path instruction accepted.
    assign fire = inst_valid_q & id_ready & ~stall & ~branch_taken;

    // FSM next-state, registered-output next values and combinational pc_sel.
    always_comb begin
        state_d      = state_q;
        im_req_d     = im_req_q;
        im_addr_d    = im_addr_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        halted_d     = halted_q;
        squash_d     = squash_q;
        req_pc_d     = req_pc_q;
        pc_sel_c     = PC_HOLD;

        case (state_q)
            IDLE: begin
                if (branch_taken) begin
                    pc_sel_c = PC_REDIRECT;
                end
                state_d = ISSUE;
            end

            ISSUE: begin
                if (branch_taken) begin
                    // Re-check the halt address against the redirected PC.
                    pc_sel_c = PC_REDIRECT;
                end else if (pc_cur == HALT_ADDR) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    im_addr_d = pc_cur[15:2];
                    req_pc_d  = pc_cur;
                    im_req_d  = 1'b1;
                    state_d   = WAIT;
                end
            end

            WAIT: begin
                if (branch_taken) begin
                    pc_sel_c = PC_REDIRECT;
                    if (im_ack) begin
                        im_req_d = 1'b0;
                        squash_d = 1'b0;
                        state_d  = ISSUE;
                    end else begin
                        // Request cannot be withdrawn; remember to drop its data.
                        squash_d = 1'b1;
                    end
                end else if (im_ack) begin
                    im_req_d = 1'b0;
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = ISSUE;
                    end else begin
                        pc_sel_c     = PC_INC;
                        inst_d       = im_rdata;
                        inst_pc_d    = req_pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = OUT;
                    end
                end
            end

            OUT: begin
                if (branch_taken) begin
                    pc_sel_c     = PC_REDIRECT;
                    inst_valid_d = 1'b0;
                    state_d      = ISSUE;
                end else if (fire) begin
                    inst_valid_d = 1'b0;
                    state_d      = ISSUE;
                end
            end

            HALT: begin
                // Terminal until reset; redirects are ignored.
                pc_sel_c = PC_HOLD;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            im_req_q     <= 1'b0;
            im_addr_q    <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            halted_q     <= 1'b0;
            squash_q     <= 1'b0;
            req_pc_q     <= '0;
        end else begin
            state_q      <= state_d;
            im_req_q     <= im_req_d;
            im_addr_q    <= im_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            halted_q     <= halted_d;
            squash_q     <= squash_d;
            req_pc_q     <= req_pc_d;
        end
    end

    assign pc_sel     = pc_sel_c;
    assign im_req     = im_req_q;
    assign im_addr    = im_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign halted     = halted_q;

`ifdef FETCH_CTRL_PERF_EN
    logic squash_evt;

    // Discarded responses (redirect with ack, or late ack of a squashed
    // request) and flushed OUT instructions.
    assign squash_evt = ((state_q == WAIT) & im_ack & (branch_taken | squash_q)) |
                        ((state_q == OUT) & branch_taken);

    fetch_perf_cnt u_perf (
        .clk             (clk),
        .rst             (rst),
        .fire            (fire),
        .squash_evt      (squash_evt),
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_squash_cnt (perf_squash_cnt)
    );
`endif

endmodule
